// File: rtl/pattern_ddr3_loader_if.sv
// Bus bundle for the pattern loader: body word stream in, DDR3 EMIF write port
// and on-chip "patterns loaded" flag port out. master = loader, slave = environment.
interface pattern_ddr3_loader_if #(
  parameter int ADDR_W = 22
);
  logic [255:0]      s_data;
  logic              s_valid;
  logic              s_ready;

  logic              ddr3_emif_ready;
  logic              ddr3_emif_write;
  logic              ddr3_emif_read;
  logic [ADDR_W-1:0] ddr3_emif_addr;
  logic [255:0]      ddr3_emif_write_data;
  logic [31:0]       ddr3_emif_byte_enable;
  logic [4:0]        ddr3_emif_burst_count;

  logic              onchip_mem_clken;
  logic              onchip_mem_chip_select;
  logic              onchip_mem_write;
  logic              onchip_mem_read;
  logic [10:0]       onchip_mem_addr;
  logic [31:0]       onchip_mem_byte_enable;
  logic [255:0]      onchip_mem_write_data;

  modport master (
    input  s_data, s_valid, ddr3_emif_ready,
    output s_ready,
    output ddr3_emif_write, ddr3_emif_read, ddr3_emif_addr, ddr3_emif_write_data,
    output ddr3_emif_byte_enable, ddr3_emif_burst_count,
    output onchip_mem_clken, onchip_mem_chip_select, onchip_mem_write, onchip_mem_read,
    output onchip_mem_addr, onchip_mem_byte_enable, onchip_mem_write_data
  );

  modport slave (
    output s_data, s_valid, ddr3_emif_ready,
    input  s_ready,
    input  ddr3_emif_write, ddr3_emif_read, ddr3_emif_addr, ddr3_emif_write_data,
    input  ddr3_emif_byte_enable, ddr3_emif_burst_count,
    input  onchip_mem_clken, onchip_mem_chip_select, onchip_mem_write, onchip_mem_read,
    input  onchip_mem_addr, onchip_mem_byte_enable, onchip_mem_write_data
  );
endinterface

// File: rtl/pattern_ddr3_loader.sv
// Write side of the DDR3 pattern store: header at word 0, body from word 1 upward,
// then the on-chip "patterns loaded" flag, which is cleared first so partial loads never look valid.
module pattern_ddr3_loader #(
  parameter int ADDR_W   = 22,
  parameter int FLAG_VAL = 85
) (
  input  logic        ddr3_emif_clk,
  input  logic        ddr3_emif_rst,
  input  logic        start,
  input  logic [31:0] cfg_h_pix,
  input  logic [31:0] cfg_v_pix,
  input  logic [31:0] cfg_total_pix,
  input  logic [31:0] cfg_pat_num,
  input  logic [31:0] cfg_fill_size,
  output logic        busy,
  output logic        done,
  output logic        error,
  pattern_ddr3_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLR, HEAD, BODY, FLAG, DONE} state_t;

  localparam logic [56:0] MAX_ADDR = 57'((64'd1 << ADDR_W) - 64'd1);

  state_t state_q, state_d;
  logic   error_q, error_d;

  logic [31:0]       h_pix_q, v_pix_q, total_q, pat_num_q, fill_q;
  logic [24:0]       wpp_q;
  logic [56:0]       mcand_q, prod_q;
  logic [31:0]       mplier_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q, body_addr_q;
  logic [255:0]      data_q;
  logic [24:0]       word_cnt_q;
  logic [31:0]       pat_cnt_q;
  logic              last_taken_q;

  logic              mul_done, overflow, s_ready_int, take, emif_ack, last_word, flag_wr;
  logic [31:0]       end_field;
  logic [255:0]      header;

  // Words per pattern; one extra word when the last one is only partially filled.
  function automatic logic [24:0] calc_wpp(input logic [31:0] t);
    return {1'b0, t[31:8]} + {24'd0, |t[7:0]};
  endfunction

  assign mul_done    = (mplier_q == 32'd0);
  assign overflow    = (prod_q > MAX_ADDR);
  assign end_field   = 32'(prod_q[ADDR_W-1:0]);
  assign header      = {h_pix_q, v_pix_q, total_q, pat_num_q, fill_q, 32'd1, end_field, 32'd0};
  assign s_ready_int = (state_q == BODY) && !last_taken_q && (!wr_q || bus.ddr3_emif_ready);
  assign take        = s_ready_int && bus.s_valid;
  assign emif_ack    = wr_q && bus.ddr3_emif_ready;
  assign last_word   = (word_cnt_q == wpp_q - 25'd1) && (pat_cnt_q == pat_num_q - 32'd1);
  assign flag_wr     = (state_q == CLR) || (state_q == FLAG);

  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      state_q <= IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (cfg_pat_num == 32'd0 || cfg_total_pix == 32'd0) begin
            state_d = DONE;
            error_d = 1'b1;
          end else begin
            state_d = CLR;
          end
        end
      end
      CLR:  state_d = HEAD;
      HEAD: begin
        if (mul_done && overflow) begin
          state_d = DONE;
          error_d = 1'b1;
        end else if (emif_ack) begin
          state_d = BODY;
        end
      end
      BODY: if (last_taken_q && emif_ack) state_d = FLAG;
      FLAG: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latched config, shift-add end_addr multiplier, one-entry EMIF output register.
  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      h_pix_q      <= '0;
      v_pix_q      <= '0;
      total_q      <= '0;
      pat_num_q    <= '0;
      fill_q       <= '0;
      wpp_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      body_addr_q  <= '0;
      word_cnt_q   <= '0;
      pat_cnt_q    <= '0;
      last_taken_q <= 1'b0;
    end else begin
      if ((state_q == CLR || state_q == HEAD) && !mul_done) begin
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            h_pix_q      <= cfg_h_pix;
            v_pix_q      <= cfg_v_pix;
            total_q      <= cfg_total_pix;
            pat_num_q    <= cfg_pat_num;
            fill_q       <= cfg_fill_size;
            wpp_q        <= calc_wpp(cfg_total_pix);
            mcand_q      <= 57'(calc_wpp(cfg_total_pix));
            mplier_q     <= cfg_pat_num;
            prod_q       <= '0;
            word_cnt_q   <= '0;
            pat_cnt_q    <= '0;
            last_taken_q <= 1'b0;
            body_addr_q  <= ADDR_W'(1);
          end
        end
        HEAD: begin
          if (!wr_q && mul_done && !overflow) begin
            wr_q   <= 1'b1;
            addr_q <= '0;
            data_q <= header;
          end else if (emif_ack) begin
            wr_q <= 1'b0;
          end
        end
        BODY: begin
          if (take) begin
            wr_q        <= 1'b1;
            addr_q      <= body_addr_q;
            data_q      <= bus.s_data;
            body_addr_q <= body_addr_q + ADDR_W'(1);
            if (word_cnt_q == wpp_q - 25'd1) begin
              word_cnt_q <= '0;
              pat_cnt_q  <= pat_cnt_q + 32'd1;
            end else begin
              word_cnt_q <= word_cnt_q + 25'd1;
            end
            if (last_word) last_taken_q <= 1'b1;
          end else if (emif_ack) begin
            wr_q <= 1'b0;
          end
        end
        default: wr_q <= 1'b0;
      endcase
    end
  end

  assign bus.s_ready                = s_ready_int;
  assign bus.ddr3_emif_write        = wr_q;
  assign bus.ddr3_emif_read         = 1'b0;
  assign bus.ddr3_emif_addr         = addr_q;
  assign bus.ddr3_emif_write_data   = data_q;
  assign bus.ddr3_emif_byte_enable  = {32{wr_q}};
  assign bus.ddr3_emif_burst_count  = 5'd1;

  assign bus.onchip_mem_clken       = flag_wr;
  assign bus.onchip_mem_chip_select = flag_wr;
  assign bus.onchip_mem_write       = flag_wr;
  assign bus.onchip_mem_read        = 1'b0;
  assign bus.onchip_mem_addr        = 11'd0;
  assign bus.onchip_mem_byte_enable = {32{flag_wr}};
  assign bus.onchip_mem_write_data  = (state_q == FLAG) ? 256'(FLAG_VAL) : 256'd0;

  assign busy  = (state_q != IDLE) && (state_q != DONE);
  assign done  = (state_q == DONE);
  assign error = error_q;

endmodule

// File: tb/tb_pattern_ddr3_loader.sv
// Self-checking bench for pattern_ddr3_loader: random body streams and EMIF back-pressure
// compared against a transaction-level model of the expected DDR3 and flag writes.
module tb_pattern_ddr3_loader;
  localparam int ADDR_W = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_h_pix = '0, cfg_v_pix = '0, cfg_total_pix = '0, cfg_pat_num = '0, cfg_fill_size = '0;
  logic        busy, done, error;

  pattern_ddr3_loader_if #(.ADDR_W(ADDR_W)) bus ();

  pattern_ddr3_loader #(.ADDR_W(ADDR_W), .FLAG_VAL(85)) dut (
    .ddr3_emif_clk (clk),
    .ddr3_emif_rst (rst),
    .start         (start),
    .cfg_h_pix     (cfg_h_pix),
    .cfg_v_pix     (cfg_v_pix),
    .cfg_total_pix (cfg_total_pix),
    .cfg_pat_num   (cfg_pat_num),
    .cfg_fill_size (cfg_fill_size),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [255:0] body_q[$];
  int           obs_addr[$];
  logic [255:0] obs_data[$];
  logic [255:0] obs_flag[$];
  int           done_cnt;
  int           ddr_at_flag;
  bit           rand_ready = 1'b0;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // EMIF back-pressure driver.
  initial begin
    bus.ddr3_emif_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ddr3_emif_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Bus monitor: logs accepted writes and checks that a stalled write holds steady.
  initial begin
    bit           pending = 1'b0;
    int           held_addr;
    logic [255:0] held_data;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          checkOutput("hold_write", 256'(bus.ddr3_emif_write), 256'd1);
          checkOutput("hold_addr", 256'(bus.ddr3_emif_addr), 256'(held_addr));
          checkOutput("hold_data", bus.ddr3_emif_write_data, held_data);
        end
        pending = 1'b0;
        if (bus.ddr3_emif_write && bus.ddr3_emif_ready) begin
          obs_addr.push_back(int'(bus.ddr3_emif_addr));
          obs_data.push_back(bus.ddr3_emif_write_data);
        end else if (bus.ddr3_emif_write) begin
          pending   = 1'b1;
          held_addr = int'(bus.ddr3_emif_addr);
          held_data = bus.ddr3_emif_write_data;
        end
        if (bus.onchip_mem_write) begin
          checkOutput("flag_strobe", 256'({bus.onchip_mem_clken, bus.onchip_mem_chip_select}), 256'd3);
          obs_flag.push_back(bus.onchip_mem_write_data);
          if (bus.onchip_mem_write_data == 256'd85) ddr_at_flag = obs_addr.size();
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] h, input logic [31:0] v, input logic [31:0] total,
                               input logic [31:0] pats, input logic [31:0] fill);
    cfg_h_pix     = h;
    cfg_v_pix     = v;
    cfg_total_pix = total;
    cfg_pat_num   = pats;
    cfg_fill_size = fill;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feedWords(input int n, input bit gaps, input bit mid_start);
    for (int i = 0; i < n; i++) begin
      bit taken = 1'b0;
      int budget = 0;
      if (gaps) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      if (mid_start && i == 1) begin
        cfg_pat_num   = 32'd7;
        cfg_total_pix = 32'd12345;
        cfg_h_pix     = 32'hDEAD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = body_q[i];
      while (!taken) begin
        @(negedge clk);
        taken = bus.s_ready;
        @(posedge clk);
        #1;
        budget++;
        if (!taken && budget > 300) begin
          checkOutput("feed_timeout", 256'd0, 256'd1);
          bus.s_valid = 1'b0;
          return;
        end
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int budget = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      budget++;
      if (budget > 3000) begin
        checkOutput({name, "_done_timeout"}, 256'd0, 256'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runLoad(input string name, input logic [31:0] h, input logic [31:0] v,
                         input logic [31:0] total, input logic [31:0] pats, input logic [31:0] fill,
                         input bit rnd, input bit mid_start);
    longint       wpp, end_addr;
    bit           cfg_err, ovf_err, exp_err;
    int           nbody, nwr;
    logic [255:0] hdr;
    wpp      = longint'(total >> 8) + ((total[7:0] != 8'd0) ? 1 : 0);
    end_addr = wpp * longint'(pats);
    cfg_err  = (pats == 0) || (total == 0);
    ovf_err  = !cfg_err && (end_addr > (longint'(1) << ADDR_W) - 1);
    exp_err  = cfg_err || ovf_err;
    nbody    = exp_err ? 0 : int'(end_addr);
    hdr      = {h, v, total, pats, fill, 32'd1, 32'(end_addr), 32'd0};

    body_q.delete();
    for (int i = 0; i < nbody; i++) body_q.push_back(rand256());
    obs_addr.delete();
    obs_data.delete();
    obs_flag.delete();
    done_cnt    = 0;
    ddr_at_flag = -1;
    rand_ready  = rnd;

    applyStimulus(h, v, total, pats, fill);
    if (!cfg_err) checkOutput({name, "_busy_after_start"}, 256'(busy), 256'd1);
    fork
      feedWords(nbody, rnd, mid_start);
      waitDone(name);
    join
    repeat (3) @(posedge clk);
    #1;
    rand_ready = 1'b0;

    checkOutput({name, "_done_pulses"}, 256'(done_cnt), 256'd1);
    checkOutput({name, "_error"}, 256'(error), 256'(exp_err));
    checkOutput({name, "_busy_idle"}, 256'(busy), 256'd0);
    nwr = exp_err ? 0 : nbody + 1;
    checkOutput({name, "_ddr_writes"}, 256'(obs_addr.size()), 256'(nwr));
    for (int i = 0; i < nwr && i < obs_addr.size(); i++) begin
      checkOutput({name, "_addr"}, 256'(obs_addr[i]), 256'(i));
      checkOutput({name, (i == 0) ? "_header" : "_body"}, obs_data[i], (i == 0) ? hdr : body_q[i-1]);
    end
    if (cfg_err) begin
      checkOutput({name, "_flag_writes"}, 256'(obs_flag.size()), 256'd0);
    end else if (ovf_err) begin
      checkOutput({name, "_flag_writes"}, 256'(obs_flag.size()), 256'd1);
      if (obs_flag.size() > 0) checkOutput({name, "_flag_clear"}, obs_flag[0], 256'd0);
    end else begin
      checkOutput({name, "_flag_writes"}, 256'(obs_flag.size()), 256'd2);
      if (obs_flag.size() > 1) begin
        checkOutput({name, "_flag_clear"}, obs_flag[0], 256'd0);
        checkOutput({name, "_flag_set"}, obs_flag[1], 256'd85);
      end
      checkOutput({name, "_flag_last"}, 256'(ddr_at_flag), 256'(nwr));
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_write", 256'(bus.ddr3_emif_write), 256'd0);
    checkOutput("rst_burst", 256'(bus.ddr3_emif_burst_count), 256'd1);
    checkOutput("rst_byte_en", 256'(bus.ddr3_emif_byte_enable), 256'd0);
    checkOutput("rst_s_ready", 256'(bus.s_ready), 256'd0);
    checkOutput("rst_onchip_wr", 256'(bus.onchip_mem_write), 256'd0);
    checkOutput("rst_onchip_data", bus.onchip_mem_write_data, 256'd0);
    checkOutput("rst_status", 256'({busy, done, error}), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    runLoad("one_pat", 32'd64, 32'd8, 32'd512, 32'd1, 32'd0, 1'b0, 1'b0);
    runLoad("two_pat", 32'd20, 32'd15, 32'd300, 32'd2, 32'd0, 1'b0, 1'b0);
    runLoad("backpress", 32'd100, 32'd7, 32'd700, 32'd3, 32'd2, 1'b1, 1'b0);
    runLoad("zero_pats", 32'd10, 32'd10, 32'd700, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("error_sticky", 256'(error), 256'd1);
    runLoad("zero_pix", 32'd10, 32'd10, 32'd0, 32'd2, 32'd0, 1'b0, 1'b0);
    runLoad("overflow", 32'd1, 32'd1, 32'h4000_0000, 32'd1, 32'd0, 1'b0, 1'b0);

    // Abort after three body words, then confirm the flag was only ever cleared.
    begin
      int budget = 0;
      body_q.delete();
      for (int i = 0; i < 6; i++) body_q.push_back(rand256());
      obs_addr.delete();
      obs_data.delete();
      obs_flag.delete();
      applyStimulus(32'd8, 32'd8, 32'd1536, 32'd1, 32'd0);
      feedWords(3, 1'b0, 1'b0);
      while (obs_addr.size() < 4 && budget < 100) begin
        @(posedge clk);
        budget++;
      end
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_ddr_writes", 256'(obs_addr.size()), 256'd4);
      checkOutput("abort_flag_writes", 256'(obs_flag.size()), 256'd1);
      if (obs_flag.size() > 0) checkOutput("abort_flag_clear", obs_flag[0], 256'd0);
      checkOutput("abort_busy", 256'(busy), 256'd0);
      @(posedge clk);
      #1;
    end
    runLoad("restart", 32'd8, 32'd8, 32'd1536, 32'd1, 32'd0, 1'b0, 1'b0);
    runLoad("mid_start", 32'd33, 32'd44, 32'd512, 32'd2, 32'd1, 1'b1, 1'b1);

    for (int n = 0; n < 4; n++) begin
      runLoad("random", $urandom, $urandom, 32'($urandom_range(1, 1200)),
              32'($urandom_range(1, 3)), 32'($urandom_range(0, 3)), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
